key_event_sequencer: RTL

//  Sits between the PS/2 scan-code receiver and the game control FSM. Parses each

---
 rtl/key_codes_pkg.sv | 67 ++++++
 rtl/key_event_sequencer_if.sv | 24 ++
 rtl/key_event_fifo.sv | 55 +++++
 rtl/key_event_sequencer.sv | 102 ++++++++++
 4 files changed

// File: rtl/key_codes_pkg.sv
// Shared scan-code constants, key ids and parser state encoding for the
// PS/2 key event sequencer.
package key_codes_pkg;

    typedef logic [3:0] key_id_t;

    localparam int NUM_KEYS = 10;

    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_PLUS  = 8'h55;
    localparam logic [7:0] SC_MINUS = 8'h4E;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_PAUSE = 8'h71;
    localparam logic [7:0] SC_RESET = 8'h2D;

    localparam key_id_t KEY_NONE  = 4'd0;
    localparam key_id_t KEY_UP    = 4'd1;
    localparam key_id_t KEY_DOWN  = 4'd2;
    localparam key_id_t KEY_LEFT  = 4'd3;
    localparam key_id_t KEY_RIGHT = 4'd4;
    localparam key_id_t KEY_PLUS  = 4'd5;
    localparam key_id_t KEY_MINUS = 4'd6;
    localparam key_id_t KEY_ENTER = 4'd7;
    localparam key_id_t KEY_ESC   = 4'd8;
    localparam key_id_t KEY_PAUSE = 4'd9;
    localparam key_id_t KEY_RESET = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } parse_state_t;

    // PAUSE is the only key whose decoding depends on the E0 prefix.
    function automatic key_id_t key_lookup(input logic [7:0] code, input logic ext);
        case (code)
            SC_UP:    return KEY_UP;
            SC_DOWN:  return KEY_DOWN;
            SC_LEFT:  return KEY_LEFT;
            SC_RIGHT: return KEY_RIGHT;
            SC_PLUS:  return KEY_PLUS;
            SC_MINUS: return KEY_MINUS;
            SC_ENTER: return KEY_ENTER;
            SC_ESC:   return KEY_ESC;
            SC_PAUSE: return ext ? KEY_PAUSE : KEY_NONE;
            SC_RESET: return KEY_RESET;
            default:  return KEY_NONE;
        endcase
    endfunction

    function automatic logic [NUM_KEYS-1:0] key_mask(input key_id_t key);
        logic [NUM_KEYS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (key == key_id_t'(i + 1)) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/key_event_sequencer_if.sv
// Scan-byte input, event handshake and status bundle of the key event sequencer.
interface key_event_sequencer_if;
    import key_codes_pkg::*;

    logic                code_valid;
    logic [7:0]          code_byte;
    logic                evt_valid;
    logic                evt_ready;
    key_id_t             evt_key;
    logic [NUM_KEYS-1:0] held_keys;
    logic                overflow;
    logic [7:0]          drop_count;

    modport master (
        output code_valid, code_byte, evt_ready,
        input  evt_valid, evt_key, held_keys, overflow, drop_count
    );

    modport slave (
        input  code_valid, code_byte, evt_ready,
        output evt_valid, evt_key, held_keys, overflow, drop_count
    );

endinterface

// File: rtl/key_event_fifo.sv
// Small circular event queue; the head word is presented from registers and
// reads as zero while the queue is empty.
module key_event_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW + 1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A pop frees the slot the push needs, so a full queue still accepts.
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is not reset; the occupancy counter alone defines which
    // entries are meaningful, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/key_event_sequencer.sv
// Parses PS/2 scan bytes into key press events, tracks held keys, suppresses
// typematic repeat and queues presses for the game logic.
module key_event_sequencer
    import key_codes_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int REPEAT_EN      = 0,
    parameter int PREFIX_TIMEOUT = 2_000_000
) (
    input logic                  clk_i,
    input logic                  rst_i,
    key_event_sequencer_if.slave bus
);

    localparam int TW = $clog2(PREFIX_TIMEOUT + 1);

    parse_state_t        state_q, state_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [NUM_KEYS-1:0] held_q, held_d, mask;
    logic                overflow_q, overflow_d;
    logic [7:0]          drop_q, drop_d;
    logic                is_brk, is_ext, push, pop, fifo_full, fifo_empty;
    key_id_t             key, push_key, head_key;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        timer_d  = '0;
        held_d   = held_q;
        push     = 1'b0;
        push_key = KEY_NONE;
        is_brk   = 1'b0;
        is_ext   = 1'b0;
        key      = KEY_NONE;
        mask     = '0;
        if (bus.code_valid) begin
            if (bus.code_byte == SC_E0) begin
                state_d = ST_EXT;
            end else if (bus.code_byte == SC_F0) begin
                state_d = (state_q == ST_EXT) ? ST_EXT_BRK : ST_BRK;
            end else begin
                state_d = ST_IDLE;
                is_brk  = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);
                is_ext  = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
                key     = key_lookup(bus.code_byte, is_ext);
                mask    = key_mask(key);
                if (is_brk) begin
                    held_d = held_q & ~mask;
                end else if (key != KEY_NONE) begin
                    held_d   = held_q | mask;
                    push     = ((held_q & mask) == '0) || (REPEAT_EN != 0);
                    push_key = key;
                end
            end
        end else if (state_q != ST_IDLE) begin
            if (timer_q == TW'(PREFIX_TIMEOUT - 1)) state_d = ST_IDLE;
            else                                    timer_d = timer_q + 1'b1;
        end
    end

    assign pop        = bus.evt_valid && bus.evt_ready;
    assign overflow_d = push && fifo_full && !pop;
    assign drop_d     = (overflow_d && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            held_q     <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            held_q     <= held_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    key_event_fifo #(
        .WIDTH ($bits(key_id_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (push_key),
        .pop_i   (pop),
        .data_o  (head_key),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.evt_valid  = !fifo_empty;
    assign bus.evt_key    = head_key;
    assign bus.held_keys  = held_q;
    assign bus.overflow   = overflow_q;
    assign bus.drop_count = drop_q;

endmodule
